// File: rtl/sha2_msg_sched.sv
// SHA-2 message schedule generator: expands one 16-word block into ROUNDS
// schedule words Wt, streamed out under a valid/ready handshake.
module sha2_msg_sched #(
  parameter int unsigned WORDSIZE = 32,
  parameter int unsigned ROUNDS   = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [16*WORDSIZE-1:0]   m_data,
  input  logic                     m_valid,
  output logic                     m_ready,
  output logic [WORDSIZE-1:0]      w_data,
  output logic                     w_valid,
  input  logic                     w_ready,
  output logic [6:0]               w_round,
  output logic                     w_last,
  output logic                     busy
);

  localparam int unsigned W = WORDSIZE;

  // Rotation / shift amounts of the small sigma functions for each variant
  localparam int unsigned S0_R1 = (W == 64) ? 1  : 7;
  localparam int unsigned S0_R2 = (W == 64) ? 8  : 18;
  localparam int unsigned S0_SH = (W == 64) ? 7  : 3;
  localparam int unsigned S1_R1 = (W == 64) ? 19 : 17;
  localparam int unsigned S1_R2 = (W == 64) ? 61 : 19;
  localparam int unsigned S1_SH = (W == 64) ? 6  : 10;

  localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state;
  logic [W-1:0]   win [16];
  logic [6:0]     round_q;
  logic [W-1:0]   w_next;
  logic           at_last;
  logic           load;

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (W - n));
  endfunction

  function automatic logic [W-1:0] sig0(input logic [W-1:0] x);
    return rotr(x, S0_R1) ^ rotr(x, S0_R2) ^ (x >> S0_SH);
  endfunction

  function automatic logic [W-1:0] sig1(input logic [W-1:0] x);
    return rotr(x, S1_R1) ^ rotr(x, S1_R2) ^ (x >> S1_SH);
  endfunction

  // Window holds W[t..t+15] with win[0] = Wt, so W[t+16] uses slots 14, 9, 1, 0
  assign w_next = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  assign at_last = (state == RUN) && (round_q == LAST_ROUND);

  // A new block is taken when idle, or alongside acceptance of the last word
  assign m_ready = !rst && ((state == IDLE) || (at_last && w_ready));
  assign load    = m_valid && m_ready;

  assign w_data  = win[0];
  assign w_valid = (state == RUN);
  assign w_round = round_q;
  assign w_last  = at_last;
  assign busy    = (state == RUN);

  // Control FSM, round counter and 16-word shift window
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      round_q <= 7'd0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (load) begin
      state   <= RUN;
      round_q <= 7'd0;
      for (int i = 0; i < 16; i++) win[i] <= m_data[(15-i)*W +: W];
    end else if ((state == RUN) && w_ready) begin
      if (at_last) begin
        state   <= IDLE;
        round_q <= 7'd0;
      end else begin
        round_q <= round_q + 7'd1;
        for (int i = 0; i < 15; i++) win[i] <= win[i+1];
        win[15] <= w_next;
      end
    end
  end

endmodule

// File: tb/tb_sha2_msg_sched.sv
// Self-checking bench for sha2_msg_sched: 32-bit and 64-bit instances
// compared against a direct recurrence model of the message schedule.
module tb_sha2_msg_sched;

  logic         clk = 1'b0;
  logic         rst;

  logic [511:0] m_data32;
  logic         m_valid32, m_ready32;
  logic [31:0]  w_data32;
  logic         w_valid32, w_ready32, w_last32, busy32;
  logic [6:0]   w_round32;

  logic [1023:0] m_data64;
  logic          m_valid64, m_ready64;
  logic [63:0]   w_data64;
  logic          w_valid64, w_ready64, w_last64, busy64;
  logic [6:0]    w_round64;

  int errors = 0;
  int checks = 0;

  logic [63:0] blk     [16];
  logic [63:0] blk_nxt [16];
  logic [63:0] exp_w   [80];

  always #5 clk = ~clk;

  sha2_msg_sched #(.WORDSIZE(32), .ROUNDS(64)) dut32 (
    .clk(clk), .rst(rst),
    .m_data(m_data32), .m_valid(m_valid32), .m_ready(m_ready32),
    .w_data(w_data32), .w_valid(w_valid32), .w_ready(w_ready32),
    .w_round(w_round32), .w_last(w_last32), .busy(busy32)
  );

  sha2_msg_sched #(.WORDSIZE(64), .ROUNDS(80)) dut64 (
    .clk(clk), .rst(rst),
    .m_data(m_data64), .m_valid(m_valid64), .m_ready(m_ready64),
    .w_data(w_data64), .w_valid(w_valid64), .w_ready(w_ready64),
    .w_round(w_round64), .w_last(w_last64), .busy(busy64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the schedule recurrence on plain integers
  function automatic logic [63:0] wmask(input int ws);
    return (ws == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int ws);
    return ((x >> n) | (x << (ws - n))) & wmask(ws);
  endfunction

  function automatic logic [63:0] s0(input logic [63:0] x, input int ws);
    if (ws == 64) return rotr(x, 1, ws) ^ rotr(x, 8, ws) ^ (x >> 7);
    return rotr(x, 7, ws) ^ rotr(x, 18, ws) ^ (x >> 3);
  endfunction

  function automatic logic [63:0] s1(input logic [63:0] x, input int ws);
    if (ws == 64) return rotr(x, 19, ws) ^ rotr(x, 61, ws) ^ (x >> 6);
    return rotr(x, 17, ws) ^ rotr(x, 19, ws) ^ (x >> 10);
  endfunction

  task automatic build_model(input int ws, input int rounds);
    for (int t = 0; t < 16; t++) exp_w[t] = blk[t] & wmask(ws);
    for (int t = 16; t < rounds; t++)
      exp_w[t] = (s1(exp_w[t-2], ws) + exp_w[t-7] + s0(exp_w[t-15], ws) + exp_w[t-16]) & wmask(ws);
  endtask

  task automatic rand_blk();
    for (int i = 0; i < 16; i++) blk[i] = {32'd0, $urandom};
  endtask

  task automatic abc_blk32();
    for (int i = 0; i < 16; i++) blk[i] = 64'd0;
    blk[0]  = 64'h6162_6380;
    blk[15] = 64'h18;
  endtask

  // Present blk on the 32-bit input and check it is taken at the next edge
  task automatic load32();
    @(negedge clk);
    for (int i = 0; i < 16; i++) m_data32[(15-i)*32 +: 32] = blk[i][31:0];
    m_valid32 = 1'b1;
    w_ready32 = 1'($urandom_range(1));
    #1;
    check("load_m_ready", 64'(m_ready32), 64'd1);
    check("load_w_valid", 64'(w_valid32), 64'd0);
  endtask

  // Consume one 32-bit block, checking every cycle against exp_w
  task automatic stream32(input int stall_pct, input bit toggle_mv, input bit b2b,
                          input int stop_at, input bit abc);
    int idx = 0;
    int cyc = 0;
    bit rdy, last;
    while (idx < 64 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      rdy  = ($urandom_range(99) >= 32'(stall_pct));
      last = (idx == 63);
      if (stop_at >= 0 && idx == stop_at) begin
        check("stop_round", 64'(w_round32), 64'(idx));
        rst       = 1'b1;
        m_valid32 = 1'b0;
        w_ready32 = rdy;
        return;
      end
      if (b2b) begin
        m_valid32 = 1'b1;
        for (int i = 0; i < 16; i++) m_data32[(15-i)*32 +: 32] = blk_nxt[i][31:0];
      end else if (toggle_mv) begin
        m_valid32 = (last && rdy) ? 1'b0 : 1'($urandom_range(1));
        for (int i = 0; i < 16; i++) m_data32[i*32 +: 32] = $urandom;
      end else begin
        m_valid32 = 1'b0;
      end
      w_ready32 = rdy;
      #1;
      check("w_valid", 64'(w_valid32), 64'd1);
      check("busy",    64'(busy32), 64'd1);
      check("w_data",  64'(w_data32), exp_w[idx]);
      check("w_round", 64'(w_round32), 64'(idx));
      check("w_last",  64'(w_last32), 64'(last));
      check("m_ready_run", 64'(m_ready32), 64'(last && rdy));
      if (abc && idx == 16) check("abc_w16", 64'(w_data32), 64'h6162_6380);
      if (abc && idx == 17) check("abc_w17", 64'(w_data32), 64'h000F_0000);
      if (rdy) idx++;
    end
    if (idx < 64) check("stream_timeout", 64'(idx), 64'd64);
  endtask

  task automatic check_idle32(input string tag);
    @(negedge clk);
    m_valid32 = 1'b0;
    #1;
    check({tag, "_w_valid"}, 64'(w_valid32), 64'd0);
    check({tag, "_busy"},    64'(busy32), 64'd0);
    check({tag, "_m_ready"}, 64'(m_ready32), 64'd1);
  endtask

  initial begin
    rst       = 1'b1;
    m_valid32 = 1'b1;
    w_ready32 = 1'b0;
    for (int i = 0; i < 16; i++) m_data32[i*32 +: 32] = $urandom;
    m_data64  = '0;
    m_valid64 = 1'b0;
    w_ready64 = 1'b1;

    // Reset state, with m_valid asserted and ignored
    repeat (2) @(negedge clk);
    #1;
    check("rst_w_valid", 64'(w_valid32), 64'd0);
    check("rst_busy",    64'(busy32), 64'd0);
    check("rst_m_ready", 64'(m_ready32), 64'd0);
    check("rst_w_last",  64'(w_last32), 64'd0);
    check("rst_w_round", 64'(w_round32), 64'd0);
    check("rst_w_data",  64'(w_data32), 64'd0);
    check("rst_w_valid64", 64'(w_valid64), 64'd0);
    @(negedge clk);
    rst       = 1'b0;
    m_valid32 = 1'b0;
    #1;
    check("idle_m_ready", 64'(m_ready32), 64'd1);
    check("idle_w_valid", 64'(w_valid32), 64'd0);

    // Padded "abc", no stalls
    abc_blk32();
    build_model(32, 64);
    load32();
    stream32(0, 1'b0, 1'b0, -1, 1'b1);
    check_idle32("abc_end");

    // Same block with 50% consumer stalls
    load32();
    stream32(50, 1'b0, 1'b0, -1, 1'b1);
    check_idle32("abc_stall_end");

    // Random blocks with m_valid/m_data noise during RUN
    for (int b = 0; b < 3; b++) begin
      rand_blk();
      build_model(32, 64);
      load32();
      stream32(30, 1'b1, 1'b0, -1, 1'b0);
      check_idle32("rand_end");
    end

    // Back-to-back blocks with m_valid held high
    rand_blk();
    build_model(32, 64);
    for (int i = 0; i < 16; i++) blk_nxt[i] = {32'd0, $urandom};
    load32();
    stream32(25, 1'b0, 1'b1, -1, 1'b0);
    for (int i = 0; i < 16; i++) blk[i] = blk_nxt[i];
    build_model(32, 64);
    stream32(25, 1'b0, 1'b0, -1, 1'b0);
    check_idle32("b2b_end");

    // Reset at round 20 discards the block
    rand_blk();
    build_model(32, 64);
    load32();
    stream32(0, 1'b0, 1'b0, 20, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_w_valid", 64'(w_valid32), 64'd0);
    check("mid_rst_busy",    64'(busy32), 64'd0);
    check("mid_rst_m_ready", 64'(m_ready32), 64'd1);
    check("mid_rst_w_round", 64'(w_round32), 64'd0);
    rand_blk();
    build_model(32, 64);
    load32();
    stream32(20, 1'b0, 1'b0, -1, 1'b0);
    check_idle32("post_rst_end");

    // 64-bit variant, padded "abc", 80 rounds
    for (int i = 0; i < 16; i++) blk[i] = 64'd0;
    blk[0]  = 64'h6162_6380_0000_0000;
    blk[15] = 64'h18;
    build_model(64, 80);
    @(negedge clk);
    for (int i = 0; i < 16; i++) m_data64[(15-i)*64 +: 64] = blk[i];
    m_valid64 = 1'b1;
    #1;
    check("w64_load_m_ready", 64'(m_ready64), 64'd1);
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      m_valid64 = 1'b0;
      #1;
      check("w64_w_valid", 64'(w_valid64), 64'd1);
      check("w64_w_data",  w_data64, exp_w[t]);
      check("w64_w_round", 64'(w_round64), 64'(t));
      check("w64_w_last",  64'(w_last64), 64'(t == 79));
      if (t == 16) check("w64_abc_w16", w_data64, 64'h6162_6380_0000_0000);
      if (t == 17) check("w64_abc_w17", w_data64, 64'h0003_0000_0000_00C0);
    end
    @(negedge clk);
    #1;
    check("w64_end_w_valid", 64'(w_valid64), 64'd0);
    check("w64_end_m_ready", 64'(m_ready64), 64'd1);
    check("w64_end_busy",    64'(busy64), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
